// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_pkg
//  Description : Command encodings, default interrupt vector and the
//                sign-extension helper shared by the PC/stack unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

    localparam logic [2:0] CMD_INC  = 3'd0;
    localparam logic [2:0] CMD_JABS = 3'd1;
    localparam logic [2:0] CMD_JREL = 3'd2;
    localparam logic [2:0] CMD_CALL = 3'd3;
    localparam logic [2:0] CMD_RET  = 3'd4;
    localparam logic [2:0] CMD_RETI = 3'd5;
    localparam logic [2:0] CMD_EI   = 3'd6;
    localparam logic [2:0] CMD_DI   = 3'd7;

    localparam logic [9:0] IRQ_VEC_DEFAULT = 10'h3F0;

    localparam int unsigned SEXT_W = 32;

    // Treats the low WIDTH bits of val as two's complement and extends to SEXT_W.
    function automatic logic [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] val,
                                               input int unsigned     width);
        logic [SEXT_W-1:0] hi_mask;
        logic [SEXT_W-1:0] sign_bit;
        hi_mask  = {SEXT_W{1'b1}} << width;
        sign_bit = SEXT_W'(1) << (width - 1);
        if ((val & sign_bit) != '0)
            return val | hi_mask;
        else
            return val & ~hi_mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ret_stack.sv
`default_nettype none
// ============================================================================
//  Module      : ret_stack
//  Description : DEPTH-entry LIFO of return addresses with occupancy flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module ret_stack #(
    parameter int PC_W  = 10,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [PC_W-1:0]              din,
    output logic [PC_W-1:0]              dout,
    output logic [$clog2(DEPTH+1)-1:0]   sp,
    output logic                         full,
    output logic                         empty
);

    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    logic [PC_W-1:0]  r_mem [DEPTH];
    logic [SP_W-1:0]  r_sp;
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_rd_idx;

    assign w_wr_idx = IDX_W'(r_sp);
    assign w_rd_idx = IDX_W'(r_sp - SP_W'(1));

    assign full  = (r_sp == SP_W'(DEPTH));
    assign empty = (r_sp == '0);
    assign sp    = r_sp;
    assign dout  = r_mem[w_rd_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sp <= '0;
        end else if (push && !full) begin
            r_sp <= r_sp + SP_W'(1);
        end else if (pop && !empty) begin
            r_sp <= r_sp - SP_W'(1);
        end
    end

    // Storage is intentionally left unreset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            r_mem[w_wr_idx] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_stack_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_stack_unit
//  Description : Program counter with conditional jumps, nested call/return
//                through a return stack, and a vectored interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_stack_unit
    import pc_pkg::*;
#(
    parameter int              PC_W    = 10,
    parameter int              DEPTH   = 8,
    parameter int              OFF_W   = 10,
    parameter logic [PC_W-1:0] IRQ_VEC = PC_W'(IRQ_VEC_DEFAULT)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall,
    input  logic [2:0]                  cmd,
    input  logic                        cond,
    input  logic [PC_W-1:0]             target,
    input  logic [OFF_W-1:0]            offset,
    input  logic                        irq,
    output logic [PC_W-1:0]             pc_out,
    output logic                        irq_ack,
    output logic                        ie,
    output logic [$clog2(DEPTH+1)-1:0]  sp_out,
    output logic                        full,
    output logic                        empty,
    output logic                        err_ovf,
    output logic                        err_unf
);

    logic [PC_W-1:0]   r_pc;
    logic              r_ie;
    logic              r_err_ovf;
    logic              r_err_unf;

    logic [PC_W-1:0]   w_inc;
    logic [SEXT_W-1:0] w_off_full;
    logic [PC_W-1:0]   w_off;
    logic [PC_W-1:0]   w_cmd_pc;
    logic [PC_W-1:0]   w_next_pc;
    logic [PC_W-1:0]   w_push_val;
    logic [PC_W-1:0]   w_dout;
    logic              w_push;
    logic              w_pop;
    logic              w_ie_nxt;
    logic              w_set_ovf;
    logic              w_set_unf;
    logic              w_irq_ok;
    logic              w_irq_take;
    logic              w_full;
    logic              w_empty;

    assign w_inc      = r_pc + PC_W'(1);
    assign w_off_full = sext(SEXT_W'(offset), OFF_W);
    assign w_off      = w_off_full[PC_W-1:0];

    always_comb begin
        w_cmd_pc  = w_inc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_ie_nxt  = r_ie;
        w_set_ovf = 1'b0;
        w_set_unf = 1'b0;
        w_irq_ok  = 1'b1;
        case (cmd)
            CMD_JABS: if (cond) w_cmd_pc = target;
            CMD_JREL: if (cond) w_cmd_pc = w_inc + w_off;
            CMD_CALL: begin
                w_irq_ok = 1'b0;
                if (cond) begin
                    if (w_full) begin
                        w_set_ovf = 1'b1;
                    end else begin
                        w_push   = 1'b1;
                        w_cmd_pc = target;
                    end
                end
            end
            CMD_RET, CMD_RETI: begin
                w_irq_ok = 1'b0;
                if (w_empty) begin
                    w_set_unf = 1'b1;
                end else begin
                    w_pop    = 1'b1;
                    w_cmd_pc = w_dout;
                end
                if (cmd == CMD_RETI) w_ie_nxt = 1'b1;
            end
            CMD_EI:  w_ie_nxt = 1'b1;
            CMD_DI:  w_ie_nxt = 1'b0;
            default: ;
        endcase

        // Interrupt pushes the address the current command would have gone to.
        w_irq_take = irq & r_ie & ~stall & ~reset & ~w_full & w_irq_ok;
        w_next_pc  = w_cmd_pc;
        w_push_val = w_inc;
        if (w_irq_take) begin
            w_next_pc  = IRQ_VEC;
            w_push_val = w_cmd_pc;
            w_push     = 1'b1;
            w_ie_nxt   = 1'b0;
        end
    end

    ret_stack #(
        .PC_W  (PC_W),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .push  (w_push & ~stall),
        .pop   (w_pop & ~stall),
        .din   (w_push_val),
        .dout  (w_dout),
        .sp    (sp_out),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= '0;
            r_ie      <= 1'b0;
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else if (!stall) begin
            r_pc      <= w_next_pc;
            r_ie      <= w_ie_nxt;
            r_err_ovf <= r_err_ovf | w_set_ovf;
            r_err_unf <= r_err_unf | w_set_unf;
        end
    end

    assign pc_out  = r_pc;
    assign ie      = r_ie;
    assign irq_ack = w_irq_take;
    assign full    = w_full;
    assign empty   = w_empty;
    assign err_ovf = r_err_ovf;
    assign err_unf = r_err_unf;

endmodule
`default_nettype wire
